// File: rtl/ser_tx_shifter_pkg.sv
// rtl/ser_tx_shifter_pkg.sv - shared state encodings and idle level for the serial transmit path
package ser_tx_shifter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    // Level driven on ser_out whenever no frame bit is on the line
    localparam logic SER_IDLE_LEVEL = 1'b0;

    function automatic logic frame_active(input state_t s);
        return s != IDLE;
    endfunction

endpackage

// File: rtl/ser_tx_bit_timer.sv
// rtl/ser_tx_bit_timer.sv - bit-period divider producing a registered terminal-count tick
module ser_tx_bit_timer #(
    parameter int CLK_DIV = 1,
    parameter int DIV_W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic tick,
    output logic tick_next
);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;

    // Divider restarts at a new word, at each bit boundary and whenever the frame stops
    always_comb begin
        div_next  = (!run || clear || tick) ? '0 : div_cnt + 1'b1;
        tick_next = run && (div_next == DIV_W'(CLK_DIV - 1));
    end

    // Tick is held in a flop so it lines up with the registered outputs of the shifter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            div_cnt <= div_next;
            tick    <= tick_next;
        end
    end

endmodule

// File: rtl/ser_tx_shifter.sv
// rtl/ser_tx_shifter.sv - parallel-to-serial shifter; optional parity bit under SER_TX_SHIFTER_PARITY_EN
module ser_tx_shifter
    import ser_tx_shifter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MSB_FIRST  = 1,
    parameter int CLK_DIV    = 1,
    parameter int CNT_W      = 4,
    parameter int DIV_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  ser_out,
    output logic                  ser_frame,
    output logic                  ser_last,
    output logic                  busy
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

    state_t                state;
    state_t                state_n;
    logic [DATA_WIDTH-1:0] sr;
    logic [DATA_WIDTH-1:0] sr_n;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      bit_n;
    logic                  start;
    logic                  tick;
    logic                  tick_next;
    logic                  last_n;
    logic                  out_bit_n;
`ifdef SER_TX_SHIFTER_PARITY_EN
    logic                  par;
    logic                  par_n;
`endif

    ser_tx_bit_timer #(
        .CLK_DIV (CLK_DIV),
        .DIV_W   (DIV_W)
    ) u_bit_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (frame_active(state_n)),
        .clear     (start),
        .tick      (tick),
        .tick_next (tick_next)
    );

    // Next-state view of the frame; outputs are registered from it so they change only on the edge
    always_comb begin
        start   = in_valid && in_ready;
        state_n = state;
        sr_n    = sr;
        bit_n   = bit_cnt;
`ifdef SER_TX_SHIFTER_PARITY_EN
        par_n   = par;
`endif
        if (start) begin
            state_n = SHIFT;
            sr_n    = in_data;
            bit_n   = '0;
`ifdef SER_TX_SHIFTER_PARITY_EN
            par_n   = ^in_data;
`endif
        end else if (tick) begin
            case (state)
                SHIFT: begin
                    if (bit_cnt == LAST_IDX) begin
                        bit_n = '0;
`ifdef SER_TX_SHIFTER_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = IDLE;
`endif
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                        sr_n  = (MSB_FIRST != 0) ? {sr[DATA_WIDTH-2:0], 1'b0}
                                                 : {1'b0, sr[DATA_WIDTH-1:1]};
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        out_bit_n = SER_IDLE_LEVEL;
        if (state_n == SHIFT) begin
            out_bit_n = (MSB_FIRST != 0) ? sr_n[DATA_WIDTH-1] : sr_n[0];
        end
`ifdef SER_TX_SHIFTER_PARITY_EN
        if (state_n == PARITY) begin
            out_bit_n = par_n;
        end
        last_n = (state_n == PARITY);
`else
        last_n = (state_n == SHIFT) && (bit_n == LAST_IDX);
`endif
    end

    // Frame state and registered outputs; in_ready opens early on the final clock of the last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sr        <= '0;
            bit_cnt   <= '0;
            in_ready  <= 1'b1;
            ser_out   <= SER_IDLE_LEVEL;
            ser_frame <= 1'b0;
            ser_last  <= 1'b0;
            busy      <= 1'b0;
`ifdef SER_TX_SHIFTER_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            sr        <= sr_n;
            bit_cnt   <= bit_n;
            in_ready  <= (state_n == IDLE) || (last_n && tick_next);
            ser_out   <= out_bit_n;
            ser_frame <= frame_active(state_n);
            ser_last  <= last_n;
            busy      <= frame_active(state_n);
`ifdef SER_TX_SHIFTER_PARITY_EN
            par       <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_ser_tx_shifter.sv
// tb/tb_ser_tx_shifter.sv - randomized and directed bench for ser_tx_shifter against a bit-stream model
module tb_ser_tx_shifter;

`ifdef SER_TX_SHIFTER_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din [3];
    logic [2:0] vld;
    logic [2:0] rdy;
    logic [2:0] so;
    logic [2:0] fr;
    logic [2:0] la;
    logic [2:0] bs;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Expected per-cycle stream entries {last, frame, bit} and pending upstream words
    logic [2:0] exq [3][64];
    int         qh [3];
    int         qc [3];
    logic [7:0] wq [3][64];
    int         wh [3];
    int         wc [3];

    bit [59:0] so_h [3];
    bit [59:0] fr_h [3];
    bit [59:0] la_h [3];
    bit [59:0] rdy_h [3];

    always #5 clk = ~clk;

    ser_tx_shifter #(.DATA_WIDTH(8), .MSB_FIRST(1), .CLK_DIV(1), .CNT_W(4), .DIV_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(din[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
        .ser_out(so[0]), .ser_frame(fr[0]), .ser_last(la[0]), .busy(bs[0]));
    ser_tx_shifter #(.DATA_WIDTH(8), .MSB_FIRST(0), .CLK_DIV(3), .CNT_W(4), .DIV_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(din[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
        .ser_out(so[1]), .ser_frame(fr[1]), .ser_last(la[1]), .busy(bs[1]));
    ser_tx_shifter #(.DATA_WIDTH(8), .MSB_FIRST(1), .CLK_DIV(2), .CNT_W(4), .DIV_W(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_data(din[2]), .in_valid(vld[2]), .in_ready(rdy[2]),
        .ser_out(so[2]), .ser_frame(fr[2]), .ser_last(la[2]), .busy(bs[2]));

    function automatic int div_of(input int i);
        case (i)
            0:       return 1;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Append the whole serial picture of one accepted word to the expected stream
    task automatic push_frame(input int i, input logic [7:0] w);
        logic b;
        for (int k = 0; k < 8 + PB; k++) begin
            if (k == 8) b = ^w;
            else        b = (i != 1) ? w[7-k] : w[k];
            for (int c = 0; c < div_of(i); c++) begin
                exq[i][(qh[i] + qc[i]) % 64] = {(k == 7 + PB), 1'b1, b};
                qc[i]++;
            end
        end
    endtask

    task automatic refresh(input int i);
        vld[i] = (wc[i] > 0);
        din[i] = (wc[i] > 0) ? wq[i][wh[i]] : 8'h00;
    endtask

    task automatic push_word(input int i, input logic [7:0] w);
        wq[i][(wh[i] + wc[i]) % 64] = w;
        wc[i]++;
        refresh(i);
    endtask

    task automatic check_inst(input int i);
        logic [2:0] e;
        logic [4:0] exp5;
        logic [4:0] obs5;
        vectors++;
        e    = (qc[i] > 0) ? exq[i][qh[i]] : 3'b000;
        exp5 = {(qc[i] <= 1), (qc[i] > 0), e};
        obs5 = {rdy[i], bs[i], la[i], fr[i], so[i]};
        assert (obs5 === exp5) else begin
            miscompares++;
            $error("FAIL inst%0d cyc%0d {rdy,busy,last,frame,out} observed=%b expected=%b",
                   i, cyc, obs5, exp5);
        end
    endtask

    // One clock: the model decides acceptance from its own ready, then all instances are checked
    task automatic step();
        bit acc [3];
        for (int i = 0; i < 3; i++) acc[i] = vld[i] && (qc[i] <= 1);
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (qc[i] > 0) begin
                qh[i] = (qh[i] + 1) % 64;
                qc[i]--;
            end
            if (acc[i]) begin
                push_frame(i, din[i]);
                wh[i] = (wh[i] + 1) % 64;
                wc[i]--;
            end
            check_inst(i);
            refresh(i);
        end
    endtask

    task automatic flush_model();
        for (int i = 0; i < 3; i++) begin
            qh[i] = 0; qc[i] = 0; wh[i] = 0; wc[i] = 0;
            refresh(i);
        end
    endtask

    initial begin
        int first;
        int last;
        int cnt;
        int ones;
        logic [7:0] sh;
        logic [7:0] lm;
        logic [7:0] rm;

        vld = 3'b000;
        for (int i = 0; i < 3; i++) din[i] = 8'h00;
        flush_model();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check_inst(i);
        rst_n = 1'b1;
        step();
        step();

        // A5 MSB-first div1, 01 LSB-first div3, FF then 00 back-to-back div2
        push_word(0, 8'hA5);
        push_word(1, 8'h01);
        push_word(2, 8'hFF);
        push_word(2, 8'h00);
        for (int s = 0; s < 60; s++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                so_h[i][s] = so[i]; fr_h[i][s] = fr[i]; la_h[i][s] = la[i]; rdy_h[i][s] = rdy[i];
            end
        end
        sh = '0; lm = '0; rm = '0;
        for (int s = 0; s < 8; s++) begin
            sh = {sh[6:0], so_h[0][s]};
            lm = {lm[6:0], la_h[0][s]};
            rm = {rm[6:0], rdy_h[0][s]};
        end
        check_val("a5_bits", 32'(sh), 32'h A5);
        check_val("a5_last_only_cycle8", 32'(lm), 32'(8'h01 * (1 - PB)));
        check_val("a5_ready_cycle8", 32'(rm), 32'(8'h01 * (1 - PB)));
        ones = 0; cnt = 0;
        for (int s = 0; s < 60; s++) begin
            ones += int'(so_h[1][s]);
            cnt  += int'(fr_h[1][s]);
        end
        check_val("div3_lsb_ones", 32'(ones), 32'(3 + 3 * PB));
        check_val("div3_frame_len", 32'(cnt), 32'(24 + 3 * PB));
        cnt = 0; first = -1; last = -1;
        for (int s = 0; s < 60; s++) begin
            if (fr_h[2][s]) begin
                cnt++;
                if (first < 0) first = s;
                last = s;
            end
        end
        check_val("stream_frame_cycles", 32'(cnt), 32'(32 + 4 * PB));
        check_val("stream_no_gap", 32'(last - first + 1), 32'(cnt));

        // Valid held through a busy frame: second word taken only on the last-bit clock
        push_word(1, 8'hC3);
        push_word(1, 8'h3C);
        first = -1;
        for (int s = 0; s < 60; s++) begin
            step();
            if (first < 0 && rdy[1] && bs[1]) first = s;
        end
        check_val("held_accept_cycle", 32'(first), 32'((8 + PB) * 3 - 1));

        // Parity-relevant words
        push_word(0, 8'h07);
        push_word(0, 8'h03);
        repeat (25) step();

        // Asynchronous reset mid-frame
        for (int i = 0; i < 3; i++) push_word(i, 8'(($urandom)));
        repeat (5) step();
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++)
            check_val($sformatf("async_reset_inst%0d", i),
                      32'({rdy[i], bs[i], la[i], fr[i], so[i]}), 32'h10);
        flush_model();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check_inst(i);
        rst_n = 1'b1;
        repeat (10) step();

        // Randomized traffic
        for (int s = 0; s < 400; s++) begin
            for (int i = 0; i < 3; i++)
                if ($urandom_range(0, 3) == 0 && wc[i] < 3) push_word(i, 8'($urandom));
            step();
        end
        repeat (60) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
